// File: rtl/rgb_fade_seq_pkg.sv
// Shared types, colour table and gamma helper for the RGB fade sequencer.
// Table entries 0..7: red, yellow, green, cyan, blue, magenta, white, dim grey.
package rgb_fade_seq_pkg;

    typedef enum logic {
        ST_FADE = 1'b0,
        ST_HOLD = 1'b1
    } fade_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int NUM_CH = 3;

    localparam rgb_t COLOR_RED     = 24'hFF0000;
    localparam rgb_t COLOR_YELLOW  = 24'hFFFF00;
    localparam rgb_t COLOR_GREEN   = 24'h00FF00;
    localparam rgb_t COLOR_CYAN    = 24'h00FFFF;
    localparam rgb_t COLOR_BLUE    = 24'h0000FF;
    localparam rgb_t COLOR_MAGENTA = 24'hFF00FF;
    localparam rgb_t COLOR_WHITE   = 24'hFFFFFF;
    localparam rgb_t COLOR_DIM     = 24'h202020;

    function automatic rgb_t color_of(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = COLOR_RED;
            3'd1:    c = COLOR_YELLOW;
            3'd2:    c = COLOR_GREEN;
            3'd3:    c = COLOR_CYAN;
            3'd4:    c = COLOR_BLUE;
            3'd5:    c = COLOR_MAGENTA;
            3'd6:    c = COLOR_WHITE;
            default: c = COLOR_DIM;
        endcase
        return c;
    endfunction

    // Gamma 2.2 curve; only ever evaluated at elaboration to fill the LUT.
    function automatic logic [7:0] gamma8(input int x);
        real lin;
        lin = real'(x) / 255.0;
        return 8'($rtoi(255.0 * (lin ** 2.2) + 0.5));
    endfunction

endpackage

// File: rtl/rgb_fade_seq_pwm8.sv
// One PWM channel: compares the shared period counter against its duty level.
// With RGB_SEQ_GAMMA_EN defined the duty passes through a registered gamma LUT first.
module rgb_fade_seq_pwm8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] pc,
    input  logic [7:0] duty,
    output logic       pwm
);

`ifdef RGB_SEQ_GAMMA_EN
    logic [7:0] gamma_lut [256];
    logic [7:0] level_reg;

    for (genvar gi = 0; gi < 256; gi++) begin : g_lut
        assign gamma_lut[gi] = rgb_fade_seq_pkg::gamma8(gi);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_reg <= '0;
            pwm       <= 1'b0;
        end else begin
            level_reg <= gamma_lut[duty];
            pwm       <= (pc < level_reg);
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm <= 1'b0;
        end else begin
            pwm <= (pc < duty);
        end
    end
`endif

endmodule

// File: rtl/rgb_fade_seq.sv
// Colour-scene scheduler: fades the RGB LED linearly through the colour table, holds, advances.
// Define RGB_SEQ_GAMMA_EN to route each duty through a gamma-2.2 LUT (one extra clk of PWM latency).
module rgb_fade_seq
    import rgb_fade_seq_pkg::*;
#(
    parameter int P_TICK_DIV   = 24000,
    parameter int P_HOLD_TICKS = 500,
    parameter int P_NUM_COLORS = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_next,
    input  logic       i_pause,
    output logic       o_pwm_r,
    output logic       o_pwm_g,
    output logic       o_pwm_b,
    output logic [2:0] o_idx,
    output logic       o_busy
);

    localparam int            TW        = $clog2(P_TICK_DIV);
    localparam int            HW        = $clog2(P_HOLD_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(P_TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(P_HOLD_TICKS - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(P_NUM_COLORS - 1);

    logic [1:0]             rst_sync_reg;
    logic                   rst_n;
    logic [2:0]             next_sync_reg;
    logic [1:0]             pause_sync_reg;
    logic                   skip_edge;
    logic                   pause;
    logic [TW-1:0]          tick_cnt_reg;
    logic                   tick;
    logic [7:0]             pc_reg;
    fade_state_t            state_reg;
    fade_state_t            state_next;
    logic [2:0]             idx_reg;
    logic [HW-1:0]          hold_cnt_reg;
    logic                   skip_latch_reg;
    rgb_t                   tgt_color;
    logic [NUM_CH-1:0][7:0] tgt;
    logic [NUM_CH-1:0][7:0] duty_reg;
    logic [NUM_CH-1:0][7:0] duty_next;
    logic                   step_done;
    logic                   fade_step;
    logic                   hold_inc;
    logic                   hold_go;
    logic                   latch_set;
    logic [NUM_CH-1:0]      pwm_vec;

    // Reset asserts immediately, releases two clocks after i_rst_n rises.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rst_sync_reg <= '0;
        else          rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
    assign rst_n = rst_sync_reg[1];

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            next_sync_reg  <= '0;
            pause_sync_reg <= '0;
            tick_cnt_reg   <= '0;
            pc_reg         <= '0;
        end else begin
            next_sync_reg  <= {next_sync_reg[1:0], i_next};
            pause_sync_reg <= {pause_sync_reg[0], i_pause};
            pc_reg         <= pc_reg + 8'd1;
            if (!pause) tick_cnt_reg <= tick ? '0 : tick_cnt_reg + TW'(1);
        end
    end

    assign skip_edge = next_sync_reg[1] & ~next_sync_reg[2];
    assign pause     = pause_sync_reg[1];
    assign tick      = !pause && (tick_cnt_reg == TICK_LAST);

    assign tgt_color = color_of(idx_reg);
    assign tgt       = {tgt_color.b, tgt_color.g, tgt_color.r};

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        assign duty_next[gi] = (duty_reg[gi] < tgt[gi]) ? duty_reg[gi] + 8'd1 :
                               (duty_reg[gi] > tgt[gi]) ? duty_reg[gi] - 8'd1 : duty_reg[gi];

        rgb_fade_seq_pwm8 u_pwm (
            .clk   (i_clk),
            .rst_n (rst_n),
            .pc    (pc_reg),
            .duty  (duty_reg[gi]),
            .pwm   (pwm_vec[gi])
        );
    end

    assign step_done = (duty_next == tgt);

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_FADE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_FADE: if (fade_step && step_done) state_next = ST_HOLD;
            ST_HOLD: if (hold_go)                state_next = ST_FADE;
            default: state_next = ST_FADE;
        endcase
    end

    // A pending or fresh skip in HOLD beats the hold timer, so only one advance results.
    always_comb begin
        o_busy    = (state_reg == ST_FADE);
        fade_step = (state_reg == ST_FADE) && tick;
        latch_set = (state_reg == ST_FADE) && skip_edge;
        hold_inc  = (state_reg == ST_HOLD) && tick;
        hold_go   = (state_reg == ST_HOLD) &&
                    (skip_edge || skip_latch_reg || (tick && hold_cnt_reg == HOLD_LAST));
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_reg       <= '0;
            idx_reg        <= '0;
            hold_cnt_reg   <= '0;
            skip_latch_reg <= 1'b0;
        end else begin
            if (fade_step) duty_reg <= duty_next;
            if (hold_go) begin
                idx_reg        <= (idx_reg == IDX_LAST) ? 3'd0 : idx_reg + 3'd1;
                skip_latch_reg <= 1'b0;
            end else if (latch_set) begin
                skip_latch_reg <= 1'b1;
            end
            if (state_reg == ST_FADE) hold_cnt_reg <= '0;
            else if (hold_inc)        hold_cnt_reg <= hold_cnt_reg + HW'(1);
        end
    end

    assign o_pwm_r = pwm_vec[0];
    assign o_pwm_g = pwm_vec[1];
    assign o_pwm_b = pwm_vec[2];
    assign o_idx   = idx_reg;

endmodule

// File: tb/tb_rgb_fade_seq.sv
// Bench for rgb_fade_seq: a per-cycle behavioural model of the fade/hold/skip rules,
// hand-computed timing literals for the directed scenarios, then a randomized phase.
module tb_rgb_fade_seq;

    localparam int DIV  = 4;
    localparam int HOLD = 3;
    localparam int NC   = 3;
    localparam logic [23:0] TABLE [8] = '{24'hFF0000, 24'hFFFF00, 24'h00FF00, 24'h00FFFF,
                                          24'h0000FF, 24'hFF00FF, 24'hFFFFFF, 24'h202020};

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       nxt   = 1'b0;
    logic       pause = 1'b0;
    logic       pwm_r, pwm_g, pwm_b, busy;
    logic [2:0] idx;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rgb_fade_seq #(
        .P_TICK_DIV   (DIV),
        .P_HOLD_TICKS (HOLD),
        .P_NUM_COLORS (NC)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_next  (nxt),
        .i_pause (pause),
        .o_pwm_r (pwm_r),
        .o_pwm_g (pwm_g),
        .o_pwm_b (pwm_b),
        .o_idx   (idx),
        .o_busy  (busy)
    );

    // Model state: duties, colour index, fade/hold phase, skip latch, tick and PWM counters.
    int m_duty [3];
    int m_idx, m_hold, m_tc, m_pc, m_rel;
    bit m_fade, m_latch;
    bit m_pwm [3];
    bit nh1, nh2, nh3, ph1, ph2;

    function automatic int target(int col, int ch);
        logic [23:0] rgb;
        rgb = TABLE[col];
        return int'((rgb >> (16 - 8 * ch)) & 24'hFF);
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_duty[c] = 0;
            m_pwm[c]  = 1'b0;
        end
        m_idx = 0; m_hold = 0; m_tc = 0; m_pc = 0; m_rel = 0;
        m_fade = 1'b1; m_latch = 1'b0;
        nh1 = 0; nh2 = 0; nh3 = 0; ph1 = 0; ph2 = 0;
    endtask

    // Inputs reach the fade logic two clocks after capture; a skip is a 0->1 in that stream.
    task automatic model_step();
        bit e, p, tick, all_eq;
        int t;
        if (!rst_n) begin
            model_reset();
        end else if (m_rel < 2) begin
            m_rel++;
            nh1 = 0; nh2 = 0; nh3 = 0; ph1 = 0; ph2 = 0;
        end else begin
            e = nh2 && !nh3;
            p = ph2;
            for (int c = 0; c < 3; c++) m_pwm[c] = (m_pc < m_duty[c]);
            m_pc = (m_pc + 1) % 256;
            tick = !p && (m_tc == DIV - 1);
            if (!p) m_tc = (m_tc + 1) % DIV;
            if (m_fade) begin
                if (e) m_latch = 1'b1;
                if (tick) begin
                    all_eq = 1'b1;
                    for (int c = 0; c < 3; c++) begin
                        t = target(m_idx, c);
                        if (m_duty[c] < t)      m_duty[c]++;
                        else if (m_duty[c] > t) m_duty[c]--;
                        if (m_duty[c] != t) all_eq = 1'b0;
                    end
                    if (all_eq) begin
                        m_fade = 1'b0;
                        m_hold = 0;
                    end
                end
            end else if (e || m_latch || (tick && m_hold + 1 == HOLD)) begin
                m_idx   = (m_idx + 1) % NC;
                m_fade  = 1'b1;
                m_latch = 1'b0;
            end else if (tick) begin
                m_hold++;
            end
            nh3 = nh2; nh2 = nh1; nh1 = nxt;
            ph2 = ph1; ph1 = pause;
        end
    endtask

    always begin
        @(posedge clk);
        model_step();
        #1;
        chk("cyc_idx",   int'(idx),   m_idx);
        chk("cyc_busy",  int'(busy),  int'(m_fade));
        chk("cyc_pwm_r", int'(pwm_r), int'(m_pwm[0]));
        chk("cyc_pwm_g", int'(pwm_g), int'(m_pwm[1]));
        chk("cyc_pwm_b", int'(pwm_b), int'(m_pwm[2]));
    end

    initial begin
        int t;
        int cnt_r, cnt_g, cnt_b;
        int idx0;

        repeat (4) @(negedge clk);
        chk("reset_pwm",  int'({pwm_r, pwm_g, pwm_b}), 0);
        chk("reset_idx",  int'(idx), 0);
        chk("reset_busy", int'(busy), 1);
        $display("reset state checked");

        // Black -> red: 255 ticks of 4 clk, plus 2 clk of reset release.
        rst_n = 1'b1;
        t = 0;
        while (t < 2000 && busy) begin @(posedge clk); #2; t++; end
        chk("first_fade_clk", t, 1022);
        while (t < 3000 && idx != 3'd1) begin @(posedge clk); #2; t++; end
        chk("first_advance_clk", t, 1034);
        $display("first fade and hold: busy fell and idx advanced");

        cnt_r = 0; cnt_b = 0;
        repeat (256) begin
            @(posedge clk); #2; t++;
            cnt_r += int'(pwm_r);
            cnt_b += int'(pwm_b);
        end
        chk("pwm_r_255", cnt_r, 255);
        chk("pwm_b_0",   cnt_b, 0);
        $display("pwm full/zero duty window checked");

        // Pause lands so that the tick taking green past 64 is blocked.
        @(posedge clk); t++;
        @(negedge clk); pause = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        cnt_g = 0;
        repeat (256) begin @(posedge clk); #2; cnt_g += int'(pwm_g); end
        chk("pwm_g_64",   cnt_g, 64);
        chk("pause_idx",  int'(idx), 1);
        chk("pause_busy", int'(busy), 1);
        @(negedge clk); pause = 1'b0;
        $display("pause mid-fade with green frozen checked");

        t = 0;
        while (t < 2000 && busy) begin @(posedge clk); #2; t++; end
        chk("reach_yellow", int'(busy), 0);
        @(negedge clk); pause = 1'b1;
        repeat (6) @(negedge clk);
        idx0 = int'(idx);
        nxt = 1'b1;
        t = 0;
        while (t < 20 && int'(idx) == idx0) begin @(posedge clk); #2; t++; end
        chk("skip_hold_latency", t, 3);
        chk("skip_hold_idx", int'(idx), 2);
        repeat (3) @(negedge clk);
        nxt = 1'b0; pause = 1'b0;
        $display("skip during paused hold checked");

        repeat (10) @(negedge clk); nxt = 1'b1;
        repeat (2)  @(negedge clk); nxt = 1'b0;
        repeat (4)  @(negedge clk); nxt = 1'b1;
        repeat (2)  @(negedge clk); nxt = 1'b0;
        t = 0;
        while (t < 2000 && busy) begin @(posedge clk); #2; t++; end
        chk("latched_fade_done", int'(busy), 0);
        chk("latched_idx_before", int'(idx), 2);
        @(posedge clk); #2;
        chk("latched_advance_idx", int'(idx), 0);
        chk("latched_advance_busy", int'(busy), 1);
        $display("two skips during fade gave one wrap advance");

        t = 0;
        while (t < 3000 && !(m_duty[1] <= 100 && (pwm_r || pwm_g))) begin
            @(posedge clk); #2; t++;
        end
        chk("found_mid_fade", int'(m_duty[1] <= 100 && (pwm_r || pwm_g)), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pwm",  int'({pwm_r, pwm_g, pwm_b}), 0);
        chk("async_rst_idx",  int'(idx), 0);
        chk("async_rst_busy", int'(busy), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        while (t < 2000 && busy) begin @(posedge clk); #2; t++; end
        chk("refade_clk", t, 1022);
        $display("async reset mid-fade and restart checked");

        repeat (4000) begin
            @(negedge clk);
            if ($urandom_range(0, 59) == 0) pause = ~pause;
            if ($urandom_range(0, 24) == 0) nxt = ~nxt;
        end
        @(negedge clk);
        pause = 1'b0;
        nxt   = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        $display("randomized phase done");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
